// File: rtl/pep_common_param_pkg.sv
// Shared types and width helpers for the PEP blind-rotation body RAM.
// Error flags are single-cycle pulses; the read request is {parity, pid}.
package pep_common_param_pkg;

  typedef struct packed {
    logic wr_ovw;
    logic rd_rst;
  } boram_error_t;

  localparam int BORAM_RD_REQ_PARITY_W = 1;

  // Width of a BORAM read request / entry address: {parity, pid}.
  function automatic int boram_rd_req_w(input int pid_w);
    return pid_w + BORAM_RD_REQ_PARITY_W;
  endfunction

endpackage

// File: rtl/pep_boram_ram.sv
// Simple dual-port body storage: one write port, one registered read port.
// Read samples the array before a same-edge write lands (read-before-write).
module pep_boram_ram #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 21,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RAM_LATENCY];

  // Array write, read capture and read-data delay line (contents need no reset).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_pipe[0] <= mem[rd_addr];
    end
    for (int i = 1; i < RAM_LATENCY; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rd_data = rd_pipe[RAM_LATENCY-1];

endmodule

// File: rtl/pep_ks_boram.sv
// Key-switch body RAM: two parity banks of LWE bodies with per-entry valid bits,
// occupancy tracking and a fixed-latency, non-backpressured read return path.
module pep_ks_boram
  import pep_common_param_pkg::*;
#(
  parameter int TOTAL_PBS_NB = 16,
  parameter int PID_W        = $clog2(TOTAL_PBS_NB),
  parameter int LWE_COEF_W   = 21,
  parameter int RAM_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  ks_boram_wr_en,
  input  logic [LWE_COEF_W-1:0] ks_boram_data,
  input  logic [PID_W-1:0]      ks_boram_pid,
  input  logic                  ks_boram_parity,
  input  logic                  boram_rd_req_vld,
  output logic                  boram_rd_req_rdy,
  input  logic [PID_W-1:0]      boram_rd_req_pid,
  input  logic                  boram_rd_req_parity,
  output logic                  boram_rd_data_avail,
  output logic [LWE_COEF_W-1:0] boram_rd_data,
  output logic [PID_W-1:0]      boram_rd_pid,
  input  logic                  reset_cache,
  output logic [PID_W+1:0]      boram_occupancy,
  output boram_error_t          boram_error
);

  localparam int ADDR_W   = boram_rd_req_w(PID_W);
  localparam int ENTRY_NB = 2 * TOTAL_PBS_NB;
  localparam int OCC_W    = PID_W + 2;
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(ENTRY_NB);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);

  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;
  logic [ENTRY_NB-1:0]   valid;
  logic [ENTRY_NB-1:0]   valid_next;
  logic                  wr_eff;
  logic                  rd_acc;
  logic                  same_entry;
  logic                  occ_inc;
  logic                  occ_dec;
  logic                  wr_ovw_next;
  logic [OCC_W-1:0]      occ_next;
  logic [RAM_LATENCY-1:0] avail_pipe;
  logic [PID_W-1:0]      pid_pipe [RAM_LATENCY];
  logic [LWE_COEF_W-1:0] ram_rd_data;

  assign wr_addr          = {ks_boram_parity, ks_boram_pid};
  assign rd_addr          = {boram_rd_req_parity, boram_rd_req_pid};
  assign boram_rd_req_rdy = valid[rd_addr] & ~reset_cache;
  assign rd_acc           = boram_rd_req_vld & boram_rd_req_rdy;
  assign wr_eff           = ks_boram_wr_en & ~reset_cache;
  // A write refilling the entry being read this cycle counts as a fresh fill.
  assign same_entry       = rd_acc & (rd_addr == wr_addr);
  assign occ_inc          = wr_eff & (~valid[wr_addr] | same_entry);
  assign occ_dec          = rd_acc;
  assign wr_ovw_next      = wr_eff & valid[wr_addr] & ~same_entry;

  // Next valid vector: read clears, write sets (write wins), cache reset clears all.
  always_comb begin
    valid_next = valid;
    for (int i = 0; i < ENTRY_NB; i++) begin
      valid_next[i] = (valid[i] & ~(rd_acc & (rd_addr == ADDR_W'(i))))
                    | (wr_eff & (wr_addr == ADDR_W'(i)));
    end
    valid_next = reset_cache ? {ENTRY_NB{1'b0}} : valid_next;
  end

  // Next occupancy, saturating at both ends.
  always_comb begin
    occ_next = boram_occupancy;
    if (reset_cache) begin
      occ_next = OCC_ZERO;
    end else begin
      case ({occ_inc, occ_dec})
        2'b10: occ_next = (boram_occupancy != OCC_MAX) ? boram_occupancy + OCC_W'(1) : boram_occupancy;
        2'b01: occ_next = (boram_occupancy != OCC_ZERO) ? boram_occupancy - OCC_W'(1) : boram_occupancy;
        default: occ_next = boram_occupancy;
      endcase
    end
  end

  // Entry-valid, occupancy and error-pulse registers.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      valid           <= {ENTRY_NB{1'b0}};
      boram_occupancy <= OCC_ZERO;
      boram_error     <= 2'b00;
    end else begin
      valid              <= valid_next;
      boram_occupancy    <= occ_next;
      boram_error.wr_ovw <= wr_ovw_next;
      boram_error.rd_rst <= reset_cache & (|avail_pipe);
    end
  end

  // Tracks accepted reads alongside the RAM read latency.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      avail_pipe <= {RAM_LATENCY{1'b0}};
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pid_pipe[i] <= {PID_W{1'b0}};
      end
    end else begin
      avail_pipe[0] <= rd_acc;
      pid_pipe[0]   <= boram_rd_req_pid;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        avail_pipe[i] <= avail_pipe[i-1];
        pid_pipe[i]   <= pid_pipe[i-1];
      end
    end
  end

  // Registered read-return port; data/pid hold between results.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      boram_rd_data_avail <= 1'b0;
      boram_rd_data       <= {LWE_COEF_W{1'b0}};
      boram_rd_pid        <= {PID_W{1'b0}};
    end else begin
      boram_rd_data_avail <= avail_pipe[RAM_LATENCY-1];
      if (avail_pipe[RAM_LATENCY-1]) begin
        boram_rd_data <= ram_rd_data;
        boram_rd_pid  <= pid_pipe[RAM_LATENCY-1];
      end
    end
  end

  pep_boram_ram #(
    .DEPTH       (ENTRY_NB),
    .ADDR_W      (ADDR_W),
    .DATA_W      (LWE_COEF_W),
    .RAM_LATENCY (RAM_LATENCY)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_eff),
    .wr_addr (wr_addr),
    .wr_data (ks_boram_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_pep_ks_boram.sv
// Directed self-checking bench for pep_ks_boram (default parameters, latency 2).
module tb_pep_ks_boram;
  import pep_common_param_pkg::*;

  logic         clk = 1'b0;
  logic         a_rst;
  logic         ks_boram_wr_en;
  logic [20:0]  ks_boram_data;
  logic [3:0]   ks_boram_pid;
  logic         ks_boram_parity;
  logic         boram_rd_req_vld;
  logic         boram_rd_req_rdy;
  logic [3:0]   boram_rd_req_pid;
  logic         boram_rd_req_parity;
  logic         boram_rd_data_avail;
  logic [20:0]  boram_rd_data;
  logic [3:0]   boram_rd_pid;
  logic         reset_cache;
  logic [5:0]   boram_occupancy;
  boram_error_t boram_error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pep_ks_boram dut (
    .clk                 (clk),
    .a_rst               (a_rst),
    .ks_boram_wr_en      (ks_boram_wr_en),
    .ks_boram_data       (ks_boram_data),
    .ks_boram_pid        (ks_boram_pid),
    .ks_boram_parity     (ks_boram_parity),
    .boram_rd_req_vld    (boram_rd_req_vld),
    .boram_rd_req_rdy    (boram_rd_req_rdy),
    .boram_rd_req_pid    (boram_rd_req_pid),
    .boram_rd_req_parity (boram_rd_req_parity),
    .boram_rd_data_avail (boram_rd_data_avail),
    .boram_rd_data       (boram_rd_data),
    .boram_rd_pid        (boram_rd_pid),
    .reset_cache         (reset_cache),
    .boram_occupancy     (boram_occupancy),
    .boram_error         (boram_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic par, input logic [3:0] pid, input logic [20:0] d);
    ks_boram_wr_en  = 1'b1;
    ks_boram_parity = par;
    ks_boram_pid    = pid;
    ks_boram_data   = d;
  endtask

  task automatic clr_wr();
    ks_boram_wr_en = 1'b0;
  endtask

  task automatic set_rd(input logic par, input logic [3:0] pid);
    boram_rd_req_vld    = 1'b1;
    boram_rd_req_parity = par;
    boram_rd_req_pid    = pid;
  endtask

  task automatic clr_rd();
    boram_rd_req_vld = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    ks_boram_wr_en = 1'b0; ks_boram_data = 21'h0; ks_boram_pid = 4'h0; ks_boram_parity = 1'b0;
    boram_rd_req_vld = 1'b0; boram_rd_req_pid = 4'h0; boram_rd_req_parity = 1'b0;
    reset_cache = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (boram_occupancy !== 6'd0) begin miscompares++; $display("FAIL rst_occ got %0d want 0", boram_occupancy); end
    vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL rst_avail got %b want 0", boram_rd_data_avail); end
    vectors++; if (boram_rd_data !== 21'h0 || boram_rd_pid !== 4'h0) begin miscompares++; $display("FAIL rst_data got %h/%0d want 0/0", boram_rd_data, boram_rd_pid); end
    vectors++; if (boram_error !== 2'b00) begin miscompares++; $display("FAIL rst_err got %b want 00", boram_error); end
    vectors++; if (boram_rd_req_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_rdy got %b want 0", boram_rd_req_rdy); end
    a_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_wr(1'b0, 4'd3, 21'h1ABCD);
    tick();
    clr_wr();
    vectors++; if (boram_occupancy !== 6'd1) begin miscompares++; $display("FAIL basic_occ1 got %0d want 1", boram_occupancy); end
    set_rd(1'b0, 4'd3);
    #1;
    vectors++; if (boram_rd_req_rdy !== 1'b1) begin miscompares++; $display("FAIL basic_rdy got %b want 1", boram_rd_req_rdy); end
    tick();
    clr_rd();
    vectors++; if (boram_occupancy !== 6'd0) begin miscompares++; $display("FAIL basic_occ0 got %0d want 0", boram_occupancy); end
    vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL basic_early0 got %b want 0", boram_rd_data_avail); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL basic_early1 got %b want 0", boram_rd_data_avail); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h1ABCD || boram_rd_pid !== 4'd3) begin
      miscompares++; $display("FAIL basic_data got avail=%b %h pid=%0d want 1 1abcd pid=3", boram_rd_data_avail, boram_rd_data, boram_rd_pid); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL basic_avail_drop got %b want 0", boram_rd_data_avail); end
  endtask

  task automatic test_unwritten();
    set_rd(1'b1, 4'd5);
    #1;
    vectors++; if (boram_rd_req_rdy !== 1'b0) begin miscompares++; $display("FAIL unwr_rdy0 got %b want 0", boram_rd_req_rdy); end
    tick();
    vectors++; if (boram_rd_req_rdy !== 1'b0) begin miscompares++; $display("FAIL unwr_rdy_held got %b want 0", boram_rd_req_rdy); end
    set_wr(1'b1, 4'd5, 21'h00042);
    #1;
    vectors++; if (boram_rd_req_rdy !== 1'b0) begin miscompares++; $display("FAIL unwr_rdy_wrcyc got %b want 0", boram_rd_req_rdy); end
    tick();
    clr_wr();
    #1;
    vectors++; if (boram_rd_req_rdy !== 1'b1) begin miscompares++; $display("FAIL unwr_rdy1 got %b want 1", boram_rd_req_rdy); end
    tick();
    clr_rd();
    tick();
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h00042 || boram_rd_pid !== 4'd5) begin
      miscompares++; $display("FAIL unwr_data got avail=%b %h pid=%0d want 1 00042 pid=5", boram_rd_data_avail, boram_rd_data, boram_rd_pid); end
    vectors++; if (boram_occupancy !== 6'd0) begin miscompares++; $display("FAIL unwr_occ got %0d want 0", boram_occupancy); end
  endtask

  task automatic test_overwrite();
    set_wr(1'b0, 4'd7, 21'h11);
    tick();
    vectors++; if (boram_error.wr_ovw !== 1'b0) begin miscompares++; $display("FAIL ovw_first got %b want 0", boram_error.wr_ovw); end
    set_wr(1'b0, 4'd7, 21'h22);
    tick();
    clr_wr();
    vectors++; if (boram_error.wr_ovw !== 1'b1) begin miscompares++; $display("FAIL ovw_pulse got %b want 1", boram_error.wr_ovw); end
    vectors++; if (boram_occupancy !== 6'd1) begin miscompares++; $display("FAIL ovw_occ got %0d want 1", boram_occupancy); end
    tick();
    vectors++; if (boram_error.wr_ovw !== 1'b0) begin miscompares++; $display("FAIL ovw_once got %b want 0", boram_error.wr_ovw); end
    set_rd(1'b0, 4'd7);
    tick();
    clr_rd();
    tick();
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h22) begin
      miscompares++; $display("FAIL ovw_data got avail=%b %h want 1 22", boram_rd_data_avail, boram_rd_data); end
    vectors++; if (boram_occupancy !== 6'd0) begin miscompares++; $display("FAIL ovw_occ0 got %0d want 0", boram_occupancy); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a;
    logic [20:0] d;
    int          avail_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      set_wr(a[4], a[3:0], 21'(32'h1000 + 32'(i) * 32'd7));
      tick();
    end
    clr_wr();
    vectors++; if (boram_occupancy !== 6'd32) begin miscompares++; $display("FAIL fill_occ got %0d want 32", boram_occupancy); end
    set_wr(1'b0, 4'd0, 21'h1000);
    tick();
    clr_wr();
    vectors++; if (boram_occupancy !== 6'd32 || boram_error.wr_ovw !== 1'b1) begin
      miscompares++; $display("FAIL full_ovw got occ=%0d ovw=%b want 32 1", boram_occupancy, boram_error.wr_ovw); end
    for (int t = 0; t < 34; t++) begin
      if (t < 32) begin
        a = 5'(t);
        set_rd(a[4], a[3:0]);
        #1;
        vectors++; if (boram_rd_req_rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_rdy%0d got %b want 1", t, boram_rd_req_rdy); end
      end else begin
        clr_rd();
      end
      tick();
      if (t >= 2) begin
        a = 5'(t - 2);
        d = 21'(32'h1000 + 32'(t - 2) * 32'd7);
        if (boram_rd_data_avail === 1'b1) avail_cnt++;
        vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== d || boram_rd_pid !== a[3:0]) begin
          miscompares++; $display("FAIL b2b_data%0d got avail=%b %h pid=%0d want 1 %h pid=%0d", t - 2, boram_rd_data_avail, boram_rd_data, boram_rd_pid, d, a[3:0]); end
      end else begin
        vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL b2b_lead%0d got %b want 0", t, boram_rd_data_avail); end
      end
    end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL b2b_tail got %b want 0", boram_rd_data_avail); end
    vectors++; if (avail_cnt !== 32) begin miscompares++; $display("FAIL b2b_count got %0d want 32", avail_cnt); end
    vectors++; if (boram_occupancy !== 6'd0) begin miscompares++; $display("FAIL b2b_occ got %0d want 0", boram_occupancy); end
  endtask

  task automatic test_same_cycle();
    set_wr(1'b1, 4'd2, 21'h10);
    tick();
    set_wr(1'b1, 4'd2, 21'h20);
    set_rd(1'b1, 4'd2);
    #1;
    vectors++; if (boram_rd_req_rdy !== 1'b1) begin miscompares++; $display("FAIL same_rdy got %b want 1", boram_rd_req_rdy); end
    tick();
    clr_wr();
    vectors++; if (boram_occupancy !== 6'd1) begin miscompares++; $display("FAIL same_occ got %0d want 1", boram_occupancy); end
    vectors++; if (boram_error !== 2'b00) begin miscompares++; $display("FAIL same_err got %b want 00", boram_error); end
    tick();
    clr_rd();
    vectors++; if (boram_occupancy !== 6'd0) begin miscompares++; $display("FAIL same_occ0 got %0d want 0", boram_occupancy); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h10 || boram_error !== 2'b00) begin
      miscompares++; $display("FAIL same_old got avail=%b %h err=%b want 1 10 00", boram_rd_data_avail, boram_rd_data, boram_error); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h20) begin
      miscompares++; $display("FAIL same_new got avail=%b %h want 1 20", boram_rd_data_avail, boram_rd_data); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL same_tail got %b want 0", boram_rd_data_avail); end
  endtask

  task automatic test_independent();
    set_wr(1'b0, 4'd10, 21'h44);
    tick();
    set_wr(1'b0, 4'd9, 21'h33);
    set_rd(1'b0, 4'd10);
    tick();
    clr_wr();
    clr_rd();
    vectors++; if (boram_occupancy !== 6'd1 || boram_error.wr_ovw !== 1'b0) begin
      miscompares++; $display("FAIL indep_occ got occ=%0d ovw=%b want 1 0", boram_occupancy, boram_error.wr_ovw); end
    tick();
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h44 || boram_rd_pid !== 4'd10) begin
      miscompares++; $display("FAIL indep_rd got avail=%b %h pid=%0d want 1 44 pid=10", boram_rd_data_avail, boram_rd_data, boram_rd_pid); end
    set_rd(1'b0, 4'd9);
    #1;
    vectors++; if (boram_rd_req_rdy !== 1'b1) begin miscompares++; $display("FAIL indep_rdy got %b want 1", boram_rd_req_rdy); end
    tick();
    clr_rd();
    tick();
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h33 || boram_rd_pid !== 4'd9) begin
      miscompares++; $display("FAIL indep_wr got avail=%b %h pid=%0d want 1 33 pid=9", boram_rd_data_avail, boram_rd_data, boram_rd_pid); end
  endtask

  task automatic test_reset_cache();
    logic [4:0] a;
    int         rdy_cnt = 0;
    set_wr(1'b0, 4'd0, 21'h0A);
    tick();
    set_wr(1'b0, 4'd1, 21'h0B);
    tick();
    set_wr(1'b1, 4'd4, 21'h0C);
    tick();
    clr_wr();
    vectors++; if (boram_occupancy !== 6'd3) begin miscompares++; $display("FAIL rc_occ3 got %0d want 3", boram_occupancy); end
    set_rd(1'b0, 4'd0);
    tick();
    set_rd(1'b0, 4'd1);
    tick();
    clr_rd();
    reset_cache = 1'b1;
    set_wr(1'b0, 4'd6, 21'h66);
    tick();
    reset_cache = 1'b0;
    clr_wr();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h0A) begin
      miscompares++; $display("FAIL rc_data0 got avail=%b %h want 1 0a", boram_rd_data_avail, boram_rd_data); end
    vectors++; if (boram_error.rd_rst !== 1'b1) begin miscompares++; $display("FAIL rc_rdrst got %b want 1", boram_error.rd_rst); end
    vectors++; if (boram_occupancy !== 6'd0) begin miscompares++; $display("FAIL rc_occ0 got %0d want 0", boram_occupancy); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b1 || boram_rd_data !== 21'h0B) begin
      miscompares++; $display("FAIL rc_data1 got avail=%b %h want 1 0b", boram_rd_data_avail, boram_rd_data); end
    vectors++; if (boram_error.rd_rst !== 1'b0) begin miscompares++; $display("FAIL rc_rdrst_once got %b want 0", boram_error.rd_rst); end
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      boram_rd_req_parity = a[4];
      boram_rd_req_pid    = a[3:0];
      #1;
      if (boram_rd_req_rdy === 1'b1) rdy_cnt++;
    end
    vectors++; if (rdy_cnt !== 0) begin miscompares++; $display("FAIL rc_all_rdy got %0d ready entries want 0", rdy_cnt); end
    tick();
    vectors++; if (boram_rd_data_avail !== 1'b0) begin miscompares++; $display("FAIL rc_tail got %b want 0", boram_rd_data_avail); end
  endtask

  task automatic test_arst_mid_read();
    int avail_cnt = 0;
    set_wr(1'b1, 4'd8, 21'h55);
    tick();
    clr_wr();
    set_rd(1'b1, 4'd8);
    tick();
    clr_rd();
    #2;
    a_rst = 1'b1;
    #1;
    vectors++; if (boram_occupancy !== 6'd0 || boram_rd_data_avail !== 1'b0) begin
      miscompares++; $display("FAIL arst_async got occ=%0d avail=%b want 0 0", boram_occupancy, boram_rd_data_avail); end
    tick();
    a_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (boram_rd_data_avail !== 1'b0) avail_cnt++;
    end
    vectors++; if (avail_cnt !== 0) begin miscompares++; $display("FAIL arst_noavail got %0d pulses want 0", avail_cnt); end
    vectors++; if (boram_rd_data !== 21'h0 || boram_rd_pid !== 4'h0) begin
      miscompares++; $display("FAIL arst_data got %h/%0d want 0/0", boram_rd_data, boram_rd_pid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unwritten();
    test_overwrite();
    test_back_to_back();
    test_same_cycle();
    test_independent();
    test_reset_cache();
    test_arst_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pep_ks_boram.md
PEP_KS_BORAM -- requirements
Module: pep_ks_boram

Interface
REQ-001 Parameter TOTAL_PBS_NB, default 16, SHALL set the number of PID entries per parity bank (power of 2).
REQ-002 Parameter PID_W, default $clog2(TOTAL_PBS_NB), SHALL set the PID field width.
REQ-003 Parameter LWE_COEF_W, default 21, SHALL set the stored body coefficient width.
REQ-004 Parameter RAM_LATENCY, default 2, SHALL set the read-request-to-data latency in cycles (>=1).
REQ-005 clk  in  1  SHALL be the single clock; all state SHALL be on its rising edge.
REQ-006 a_rst  in  1  SHALL be the reset: asynchronous and active-high.
REQ-007 ks_boram_wr_en  in  1  SHALL qualify a body write from the key switch.
REQ-008 ks_boram_data  in  LWE_COEF_W  SHALL carry the key-switched LWE body coefficient.
REQ-009 ks_boram_pid  in  PID_W  SHALL carry the target PID.
REQ-010 ks_boram_parity  in  1  SHALL select the target bank.
REQ-011 boram_rd_req_vld / boram_rd_req_rdy  in/out  1/1  SHALL form the consumer read-request handshake.
REQ-012 boram_rd_req_pid / boram_rd_req_parity  in  PID_W/1  SHALL address the read.
REQ-013 boram_rd_data_avail / boram_rd_data / boram_rd_pid  out  1/LWE_COEF_W/PID_W  SHALL return read data, no backpressure.
REQ-014 reset_cache  in  1  SHALL clear all entry-valid state.
REQ-015 boram_occupancy  out  PID_W+2  SHALL report the number of valid entries over both banks.
REQ-016 boram_error  out  boram_error_t  SHALL carry 1-cycle error pulses: wr_ovw, rd_rst.

Function
REQ-017 Storage SHALL be 2 banks x TOTAL_PBS_NB words of LWE_COEF_W, plus one valid bit per word.
REQ-018 A write (wr_en=1) SHALL store data at [parity][pid] and set its valid bit on the next edge.
REQ-019 A write to an already-valid entry not consumed that same cycle SHALL overwrite the data and pulse boram_error.wr_ovw one cycle later.
REQ-020 boram_rd_req_rdy SHALL be combinationally 1 iff the addressed entry's valid bit is 1 and reset_cache=0.
REQ-021 An accepted read (vld&rdy at edge N) SHALL clear the entry's valid bit at edge N and drive rd_data_avail=1 with data and pid exactly RAM_LATENCY cycles after N.
REQ-022 Reads SHALL be fully pipelined: one accepted read per cycle, back-to-back, in order.
REQ-023 Simultaneous write and accepted read of the same entry: the read SHALL return the old data, the entry SHALL end valid with the new data, no wr_ovw.
REQ-024 Write and read of different entries in the same cycle SHALL both complete independently.
REQ-025 boram_occupancy SHALL be +1 per write to an invalid entry, -1 per accepted read, net 0 for REQ-023; it SHALL never wrap (max 2*TOTAL_PBS_NB).
REQ-026 reset_cache=1 SHALL clear all valid bits and occupancy at the next edge; a write in the same cycle SHALL be dropped.
REQ-027 Reads accepted before reset_cache SHALL still deliver their data; if any read is in flight when reset_cache asserts, boram_error.rd_rst SHALL pulse.
REQ-028 rd_data_avail SHALL be 0 whenever no read result is due.

Reset
REQ-029 On a_rst: all valid bits 0, occupancy 0, rd_data_avail 0, rd_data 0, rd_pid 0, in-flight pipeline flushed, boram_error 0.
REQ-030 RAM data contents SHALL NOT require reset.
REQ-031 Reset asserted mid-read SHALL discard the pending data with no avail pulse after reset release.

Structure
REQ-032 boram_error_t and the BORAM read-request width constant SHALL be defined in pep_common_param_pkg.
REQ-033 Data storage SHALL be one sub-module, pep_boram_ram (1W1R, registered read, latency RAM_LATENCY); valid bits, occupancy and control SHALL live in pep_ks_boram.

Verification
REQ-034 Write pid=3 parity=0 data=0x1ABCD; read pid=3 parity=0 next cycle -> rdy=1, avail at accept+2 with data 0x1ABCD, pid 3; occupancy 0->1->0.
REQ-035 Read pid=5 parity=1 never written -> rdy=0 held; write it with 0x00042 -> rdy=1 next cycle, data 0x00042 returned.
REQ-036 Write pid=7 parity=0 twice (0x11, 0x22) without read -> wr_ovw pulse once; read returns 0x22; occupancy stays 1.
REQ-037 Fill all 32 entries, read all back-to-back -> 32 consecutive avail cycles in request order; occupancy 32 then 0.
REQ-038 Write and read pid=2 parity=1 same cycle (old 0x10, new 0x20) -> read returns 0x10, second read returns 0x20, no error.
REQ-039 Two reads in flight then reset_cache -> both data delivered, rd_rst pulses, occupancy 0, all rdy=0; a_rst mid-read -> no avail after release.
